// File: rtl/button_repeat.sv
// rtl/button_repeat.sv - press-and-hold auto-repeat for the duty-cycle inc/dec buttons
// Emits one step on press, a second after HOLD_DELAY, then one every REPEAT_PERIOD.
module button_repeat #(
    parameter int HOLD_DELAY    = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int CNT_WIDTH     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_in,
    input  logic dec_in,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_HOLD,
        S_REPEAT,
        S_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_INC  = 2'b01,
        DIR_DEC  = 2'b10
    } dir_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_DELAY - 2);
    localparam logic [CNT_WIDTH-1:0] REP_LOAD  = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state, state_n;
    dir_t                 dir, dir_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 fire;
    logic                 captured, opposite;
    logic                 inc_pulse_n, dec_pulse_n, active_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOCKED;
            dir       <= DIR_NONE;
            cnt       <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
            inc_pulse <= inc_pulse_n;
            dec_pulse <= dec_pulse_n;
            active    <= active_n;
        end
    end

    always_comb begin
        state_n  = state;
        dir_n    = dir;
        cnt_n    = cnt;
        fire     = 1'b0;
        captured = (dir == DIR_INC) ? inc_in : dec_in;
        opposite = (dir == DIR_INC) ? dec_in : inc_in;

        case (state)
            S_IDLE: begin
                if (inc_in ^ dec_in) begin
                    state_n = S_FIRST;
                    dir_n   = inc_in ? DIR_INC : DIR_DEC;
                    fire    = 1'b1;
                end else if (inc_in && dec_in) begin
                    state_n = S_LOCKED;
                end
            end
            S_FIRST, S_HOLD, S_REPEAT: begin
                // Abort checks take precedence over any counter action.
                if (opposite) begin
                    state_n = S_LOCKED;
                end else if (!captured) begin
                    state_n = S_IDLE;
                end else if (state == S_FIRST) begin
                    cnt_n   = HOLD_LOAD;
                    state_n = S_HOLD;
                end else if (cnt == '0) begin
                    fire    = 1'b1;
                    cnt_n   = REP_LOAD;
                    state_n = S_REPEAT;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            S_LOCKED: begin
                if (!inc_in && !dec_in) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_LOCKED;
        endcase

        inc_pulse_n = fire && (dir_n == DIR_INC);
        dec_pulse_n = fire && (dir_n == DIR_DEC);
        active_n    = (state_n == S_FIRST) || (state_n == S_HOLD) || (state_n == S_REPEAT);
    end

endmodule

// File: doc/button_repeat.md
# button_repeat

Press-and-hold auto-repeat stage for the duty-cycle buttons. Sits between the debouncer outputs and the PWM duty inputs. Converts the two level inputs (increase/decrease) into single-cycle step pulses: one immediately on press, then repeated steps while the button stays held. Enforces mutual exclusion, so simultaneous presses never produce steps.

## Interface
- HOLD_DELAY, 50000, clock cycles from the first pulse to the second pulse (0.5 s at 100 kHz); legal range ≥ 2
- REPEAT_PERIOD, 10000, clock cycles between subsequent repeat pulses (0.1 s at 100 kHz); legal range ≥ 2
- CNT_WIDTH, 17, counter width; must hold max(HOLD_DELAY, REPEAT_PERIOD) − 1

- clk  input  1  system clock, ~100 kHz, rising edge
- rst  input  1  synchronous, active-high reset
- inc_in  input  1  increase request level, already synchronized/debounced
- dec_in  input  1  decrease request level, already synchronized/debounced
- inc_pulse  output  1  one-cycle increase step, registered
- dec_pulse  output  1  one-cycle decrease step, registered
- active  output  1  high while a button press is being serviced (state FIRST/HOLD/REPEAT), registered

## Operation
- The FSM has five states: IDLE, FIRST, HOLD, REPEAT, LOCKED.
- A 2-bit direction register `dir` records which button was captured: INC or DEC.
- One down-counter `cnt` of width CNT_WIDTH.
- Reset sets state=LOCKED, cnt=0, and all outputs 0. A button held through reset therefore produces no step until it is released.
- IDLE:
  - exactly one input high → FIRST; capture dir; pulse for dir asserted on the same edge.
  - both inputs high → LOCKED.
  - neither high → stay in IDLE.
- FIRST (lasts one cycle): load cnt=HOLD_DELAY−2 → HOLD.
- HOLD:
  - cnt==0 → pulse for dir; load cnt=REPEAT_PERIOD−1 → REPEAT.
  - otherwise cnt−1.
- REPEAT:
  - cnt==0 → pulse for dir; reload cnt=REPEAT_PERIOD−1.
  - otherwise cnt−1.
- Abort, in FIRST/HOLD/REPEAT, checked before the counter actions, with priority in this order:
  - the opposite input goes high → LOCKED, no pulse that cycle.
  - the captured input goes low → IDLE, no pulse that cycle.
- LOCKED: no pulses are emitted. Go to IDLE when both inputs are low.
- inc_pulse and dec_pulse are never high in the same cycle.
- active is high exactly in FIRST/HOLD/REPEAT.
- The counter never wraps: it is only reloaded, never decremented below 0.

## Timing
- All outputs are registered. Let edge E be the first rising edge at which the FSM is in IDLE with a single input sampled high.
- First pulse: high during cycle E→E+1 (one-cycle latency from the sample).
- Second pulse: at edge E+HOLD_DELAY.
- k-th pulse (k ≥ 2): at edge E+HOLD_DELAY+(k−2)·REPEAT_PERIOD.
- Release sampled at edge R → no pulse at R or later; state is IDLE after R.
- Re-press sampled at R+1 → a new first pulse at R+1. Minimum press-to-press gap is one low cycle.
- rst asserted mid-hold → outputs 0 at the next edge; state LOCKED.
- rst dominates all other inputs.

## Test plan
Parameters for all scenarios: HOLD_DELAY=5, REPEAT_PERIOD=3.
- Reset with inc_in held high, then release rst → inc_pulse stays 0 until inc_in goes low for 1 cycle and is raised again.
- inc_in high for 1 cycle from IDLE → exactly one inc_pulse, one cycle wide; active high for 1 cycle, then 0.
- inc_in held for 15 cycles from edge E → inc_pulse at E, E+5, E+8, E+11, E+14 and no others; dec_pulse stays 0.
- dec_in held, then inc_in raised at E+6 → dec_pulse only at E and E+5; no pulses afterwards. Release both → IDLE; dec_in re-press then gives a fresh dec_pulse.
- inc_in and dec_in rise on the same edge → no pulses, state LOCKED. Drop only dec_in → still no pulses until both are low.
- rst pulsed at E+6 during an inc hold → inc_pulse and active low from E+7; no pulse at E+8.
